icache: RTL and testbench
=========================

// Module: icache
// PURPOSE
//  Direct-mapped, one-word-per-line instruction cache between the fetch stage and the memory controller.
//  Serves fetch-stage PC lookups. A hit is answered in 1 cycle.
//  On a miss it issues one word-read to the memory controller (ic_flag/ins_addr) and waits for ins/ins_rdy.
//  It then fills the line and returns the word to fetch.
// PARAMETERS
//  INDEX_BITS  6   line count = 2**INDEX_BITS; index = pc[INDEX_BITS+1:2], tag = pc[31:INDEX_BITS+2]
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous active-high reset
//  rdy          in   1   global ready; when low, every register holds its value
//  fetch_req    in   1   fetch wants the word at fetch_pc this cycle
//  fetch_pc     in   32  word-aligned fetch address (pc[1:0] ignored)
//  fetch_clear  in   1   branch flush: abandon the current request (the fill still completes)
//  ins_out      out  32  instruction word returned to fetch
//  ins_valid    out  1   1-cycle pulse: ins_out is valid for ins_pc
//  ins_pc       out  32  address that ins_out belongs to
//  busy         out  1   1 while a miss is outstanding; fetch must not raise fetch_req
//  ic_flag      out  1   to memory controller: 1-cycle request pulse
//  ins_addr     out  32  to memory controller: miss address, held stable from ic_flag until ins_rdy
//  ic_enable    in   1   from memory controller: controller idle (informational only; not required to issue)
//  ins          in   32  from memory controller: fetched word
//  ins_rdy      in   1   from memory controller: 1-cycle pulse, ins is valid
// BEHAVIOUR
//  Reset (rst=1 at posedge, takes priority over rdy):
//   - all valid bits cleared; state=IDLE
//   - ic_flag=0, ins_valid=0, busy=0, ins_out=0, ins_pc=0, ins_addr=0
//   - reset mid-miss drops the miss; a later ins_rdy pulse is ignored in IDLE
//  rdy=0: no state, array or output changes; a pending ins_rdy pulse in that cycle is lost.
//   The memory controller is frozen by the same rdy, so this cannot occur.
//  States:
//   IDLE:
//    - fetch_req & hit (valid[idx] & tag match) -> next cycle ins_valid=1, ins_out=data[idx], ins_pc=fetch_pc; stay IDLE
//    - fetch_req & miss -> next cycle ic_flag=1 (exactly one cycle), ins_addr={fetch_pc[31:2],2'b00},
//      busy=1, ins_valid=0; go to WAIT_MEM and latch fetch_pc as miss_pc
//    - fetch_clear in IDLE overrides fetch_req: no lookup, no request
//   WAIT_MEM:
//    - ic_flag=0 after the first cycle; ins_addr and busy held
//    - fetch_clear sets drop=1
//    - on ins_rdy: write data[idx(miss_pc)]=ins, tag, valid=1
//    - next cycle: ins_valid=!drop (drop includes a fetch_clear in the ins_rdy cycle itself),
//      ins_out=ins, ins_pc=miss_pc, busy=0, drop=0, go to IDLE
//  Timing:
//   - ins_valid is registered and lasts exactly one cycle, never two in a row for the same request
//   - a fetch_req in the cycle ins_valid is high is accepted normally
//   - miss latency = controller latency + 2 cycles (issue + return)
//  ic_flag is a single pulse: the memory controller latches it while busy with LSB traffic.
//   Re-asserting would cause a duplicate read, so it is forbidden.
//  Same-index conflict: a fill overwrites the line unconditionally.
//   A hit lookup in the fill-writeback cycle cannot occur because busy=1.
//  Array is write-first only for the fill; lookups are purely IDLE and combinational on fetch_pc.
// STRUCTURE
//  - shared defines header: IC_IDLE/IC_WAIT_MEM state codes, XLEN=32
//  - one sub-module icache_array: valid/tag/data storage; combinational read port (idx -> hit, word);
//    synchronous write port (we, idx, tag, word); synchronous clear on rst
//  - top holds the FSM, miss_pc, drop and output registers
// TESTING
//  1 Cold miss: reset, fetch_req pc=0x0000_0000
//    -> ic_flag pulse 1 cycle with ins_addr=0x0, busy=1; bench returns ins_rdy, ins=0x0000_0013 after 8 cycles
//    -> ins_valid 1 cycle later, ins_out=0x13, ins_pc=0x0
//  2 Hit: repeat pc=0x0 -> ins_valid the next cycle, ins_out=0x13, no ic_flag
//  3 Conflict: with INDEX_BITS=6, fetch pc=0x100 (same index 0) -> miss, fill 0x0010_0093
//    -> then pc=0x0 misses again (line evicted)
//  4 Flush: miss on pc=0x40, assert fetch_clear 3 cycles in -> ins_rdy fills the line, ins_valid stays 0
//    -> next fetch pc=0x40 hits
//  5 Delayed controller: hold ins_rdy off 30 cycles, ic_enable=0
//    -> ic_flag asserted once only, ins_addr stable throughout
//  6 Reset mid-miss and rdy stall: rst during WAIT_MEM -> all outputs 0, a stray ins_rdy is ignored,
//    pc=0x0 misses; rdy=0 for 5 cycles on a hit -> ins_valid delayed 5 cycles, value unchanged

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: data width, FSM state codes
// and a small address helper.
package icache_pkg;

    localparam int XLEN = 32;

    typedef enum logic [0:0] {
        IC_IDLE     = 1'b0,
        IC_WAIT_MEM = 1'b1
    } ic_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
// The cache uses the slave modport; fetch stage plus memory controller use master.
interface icache_if;
    import icache_pkg::*;

    logic            fetch_req;
    logic [XLEN-1:0] fetch_pc;
    logic            fetch_clear;
    logic [XLEN-1:0] ins_out;
    logic            ins_valid;
    logic [XLEN-1:0] ins_pc;
    logic            busy;
    logic            ic_flag;
    logic [XLEN-1:0] ins_addr;
    logic            ic_enable;
    logic [XLEN-1:0] ins;
    logic            ins_rdy;

    modport slave (
        input  fetch_req, fetch_pc, fetch_clear, ic_enable, ins, ins_rdy,
        output ins_out, ins_valid, ins_pc, busy, ic_flag, ins_addr
    );

    modport master (
        output fetch_req, fetch_pc, fetch_clear, ic_enable, ins, ins_rdy,
        input  ins_out, ins_valid, ins_pc, busy, ic_flag, ins_addr
    );

endinterface

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational lookup port, synchronous fill port,
// valid bits cleared synchronously on rst.
module icache_array
    import icache_pkg::*;
#(
    parameter  int INDEX_BITS = 6,
    localparam int TAG_BITS   = XLEN - INDEX_BITS - 2,
    localparam int LINES      = 1 << INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx,
    input  logic [TAG_BITS-1:0]   rd_tag,
    output logic                  rd_hit,
    output logic [XLEN-1:0]       rd_word,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [XLEN-1:0]       wr_word
);

    logic [LINES-1:0]    valid_reg;
    logic [LINES-1:0]    line_set;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [XLEN-1:0]     data_mem [LINES];

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_line_set
            assign line_set[gi] = we && (wr_idx == INDEX_BITS'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_reg | line_set;
        end
    end

    // Tag and data need no reset: a line is only consulted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_word;
        end
    end

    assign rd_hit  = valid_reg[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_word = data_mem[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache: 1-cycle hits, single
// word-read to the memory controller on a miss, then fill and return.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    icache_if.slave  io
);

    localparam int TAG_BITS = XLEN - INDEX_BITS - 2;

    ic_state_t       state_reg;
    logic [XLEN-1:0] miss_pc_reg;
    logic            drop_reg;
    logic [XLEN-1:0] ins_out_reg;
    logic            ins_valid_reg;
    logic [XLEN-1:0] ins_pc_reg;
    logic            busy_reg;
    logic            ic_flag_reg;
    logic [XLEN-1:0] ins_addr_reg;

    logic            rd_hit;
    logic [XLEN-1:0] rd_word;
    logic            fill_we;

    // Controller-idle status is informational; requests are issued regardless.
    logic unused_ok;
    assign unused_ok = &{1'b0, io.ic_enable};

    assign fill_we = rdy && !rst && (state_reg == IC_WAIT_MEM) && io.ins_rdy;

    icache_array #(
        .INDEX_BITS (INDEX_BITS)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (io.fetch_pc[INDEX_BITS+1:2]),
        .rd_tag  (io.fetch_pc[XLEN-1:INDEX_BITS+2]),
        .rd_hit  (rd_hit),
        .rd_word (rd_word),
        .we      (fill_we),
        .wr_idx  (miss_pc_reg[INDEX_BITS+1:2]),
        .wr_tag  (miss_pc_reg[XLEN-1:INDEX_BITS+2]),
        .wr_word (io.ins)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IC_IDLE;
            miss_pc_reg   <= '0;
            drop_reg      <= 1'b0;
            ins_out_reg   <= '0;
            ins_valid_reg <= 1'b0;
            ins_pc_reg    <= '0;
            busy_reg      <= 1'b0;
            ic_flag_reg   <= 1'b0;
            ins_addr_reg  <= '0;
        end else if (rdy) begin
            ins_valid_reg <= 1'b0;
            ic_flag_reg   <= 1'b0;
            case (state_reg)
                IC_IDLE: begin
                    if (io.fetch_req && !io.fetch_clear) begin
                        if (rd_hit) begin
                            ins_valid_reg <= 1'b1;
                            ins_out_reg   <= rd_word;
                            ins_pc_reg    <= io.fetch_pc;
                        end else begin
                            ic_flag_reg  <= 1'b1;
                            ins_addr_reg <= word_align(io.fetch_pc);
                            busy_reg     <= 1'b1;
                            miss_pc_reg  <= io.fetch_pc;
                            state_reg    <= IC_WAIT_MEM;
                        end
                    end
                end
                IC_WAIT_MEM: begin
                    if (io.fetch_clear) begin
                        drop_reg <= 1'b1;
                    end
                    // A flush in the return cycle itself still suppresses delivery.
                    if (io.ins_rdy) begin
                        ins_valid_reg <= !(drop_reg || io.fetch_clear);
                        ins_out_reg   <= io.ins;
                        ins_pc_reg    <= miss_pc_reg;
                        busy_reg      <= 1'b0;
                        drop_reg      <= 1'b0;
                        state_reg     <= IC_IDLE;
                    end
                end
                default: state_reg <= IC_IDLE;
            endcase
        end
    end

    assign io.ins_out   = ins_out_reg;
    assign io.ins_valid = ins_valid_reg;
    assign io.ins_pc    = ins_pc_reg;
    assign io.busy      = busy_reg;
    assign io.ic_flag   = ic_flag_reg;
    assign io.ins_addr  = ins_addr_reg;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table, hand-written reset/stall
// sequences, then random fetches checked against an address-level cache model.
module tb_icache;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    icache_if bus ();

    icache #(.INDEX_BITS(6)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .io  (bus)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] fill;
        int          lat;
        int          clr;
        bit          ic_en;
        bit          miss;
        bit          vld;
        logic [31:0] out;
    } vec_t;

    vec_t vecs [7];

    // Model: which word address each line currently holds.
    logic [31:0] model_line [int];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    function automatic int line_of(input logic [31:0] addr);
        return int'((addr >> 2) % 64);
    endfunction

    task automatic do_fetch(input string name, input logic [31:0] pc, input logic [31:0] fill,
                            input int lat, input int clr, input bit ic_en,
                            input bit exp_miss, input bit exp_valid, input logic [31:0] exp_out);
        logic [31:0] addr0;
        int extra;
        int moved;
        bus.ic_enable = ic_en;
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = pc;
        step();
        bus.fetch_req = 1'b0;
        if (!exp_miss) begin
            check({name, ".hit_valid"}, 32'(bus.ins_valid), 32'd1);
            check({name, ".hit_out"}, bus.ins_out, exp_out);
            check({name, ".hit_pc"}, bus.ins_pc, pc);
            check({name, ".hit_noflag"}, 32'(bus.ic_flag), 32'd0);
        end else begin
            check({name, ".flag"}, 32'(bus.ic_flag), 32'd1);
            check({name, ".addr"}, bus.ins_addr, {pc[31:2], 2'b00});
            check({name, ".busy"}, 32'(bus.busy), 32'd1);
            addr0 = bus.ins_addr;
            extra = 0;
            moved = 0;
            for (int c = 0; c < lat; c++) begin
                bus.fetch_clear = (c == clr);
                step();
                if (bus.ic_flag !== 1'b0) extra++;
                if (bus.ins_addr !== addr0 || bus.busy !== 1'b1 || bus.ins_valid !== 1'b0) moved++;
            end
            bus.fetch_clear = (clr == lat);
            bus.ins_rdy     = 1'b1;
            bus.ins         = fill;
            step();
            bus.ins_rdy     = 1'b0;
            bus.fetch_clear = 1'b0;
            bus.ins         = $urandom;
            check({name, ".flag_once"}, 32'(extra), 32'd0);
            check({name, ".wait_stable"}, 32'(moved), 32'd0);
            check({name, ".ret_valid"}, 32'(bus.ins_valid), 32'(exp_valid));
            check({name, ".ret_busy"}, 32'(bus.busy), 32'd0);
            if (exp_valid) begin
                check({name, ".ret_out"}, bus.ins_out, exp_out);
                check({name, ".ret_pc"}, bus.ins_pc, pc);
            end
            step();
            check({name, ".pulse_end"}, 32'(bus.ins_valid), 32'd0);
        end
        bus.ic_enable = 1'b1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, ".flag"}, 32'(bus.ic_flag), 32'd0);
        check({name, ".valid"}, 32'(bus.ins_valid), 32'd0);
        check({name, ".busy"}, 32'(bus.busy), 32'd0);
        check({name, ".out"}, bus.ins_out, 32'd0);
        check({name, ".pc"}, bus.ins_pc, 32'd0);
        check({name, ".addr"}, bus.ins_addr, 32'd0);
    endtask

    initial begin
        int stall_bad;
        vecs[0] = '{pc: 32'h0,  fill: 32'h0000_0013, lat: 8,  clr: -1, ic_en: 1'b1, miss: 1'b1, vld: 1'b1, out: 32'h0000_0013};
        vecs[1] = '{pc: 32'h0,  fill: 32'h0,         lat: 0,  clr: -1, ic_en: 1'b1, miss: 1'b0, vld: 1'b1, out: 32'h0000_0013};
        vecs[2] = '{pc: 32'h100, fill: 32'h0010_0093, lat: 3, clr: -1, ic_en: 1'b1, miss: 1'b1, vld: 1'b1, out: 32'h0010_0093};
        vecs[3] = '{pc: 32'h0,  fill: 32'h0000_0013, lat: 2,  clr: -1, ic_en: 1'b1, miss: 1'b1, vld: 1'b1, out: 32'h0000_0013};
        vecs[4] = '{pc: 32'h40, fill: 32'hDEAD_BEEF, lat: 6,  clr: 3,  ic_en: 1'b1, miss: 1'b1, vld: 1'b0, out: 32'h0};
        vecs[5] = '{pc: 32'h40, fill: 32'h0,         lat: 0,  clr: -1, ic_en: 1'b1, miss: 1'b0, vld: 1'b1, out: 32'hDEAD_BEEF};
        vecs[6] = '{pc: 32'h80, fill: 32'h0000_0055, lat: 30, clr: -1, ic_en: 1'b0, miss: 1'b1, vld: 1'b1, out: 32'h0000_0055};

        rst = 1'b1;
        rdy = 1'b1;
        bus.fetch_req   = 1'b0;
        bus.fetch_pc    = '0;
        bus.fetch_clear = 1'b0;
        bus.ic_enable   = 1'b1;
        bus.ins         = '0;
        bus.ins_rdy     = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_fetch($sformatf("vec%0d", i), vecs[i].pc, vecs[i].fill, vecs[i].lat, vecs[i].clr,
                     vecs[i].ic_en, vecs[i].miss, vecs[i].vld, vecs[i].out);
        end

        // Reset during an outstanding miss, then a stray return pulse.
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = 32'h200;
        step();
        bus.fetch_req = 1'b0;
        check("midmiss.flag", 32'(bus.ic_flag), 32'd1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("midrst");
        bus.ins_rdy = 1'b1;
        bus.ins     = 32'h0BAD_0BAD;
        step();
        bus.ins_rdy = 1'b0;
        check("stray.valid", 32'(bus.ins_valid), 32'd0);
        check("stray.busy", 32'(bus.busy), 32'd0);
        check("stray.out", bus.ins_out, 32'd0);
        do_fetch("postrst", 32'h0, 32'h0000_0013, 1, -1, 1'b1, 1'b1, 1'b1, 32'h0000_0013);

        // rdy low for 5 cycles while a hit is requested.
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = 32'h0;
        rdy = 1'b0;
        stall_bad = 0;
        repeat (5) begin
            step();
            if (bus.ins_valid !== 1'b0) stall_bad++;
        end
        rdy = 1'b1;
        step();
        bus.fetch_req = 1'b0;
        check("stall.quiet", 32'(stall_bad), 32'd0);
        check("stall.valid", 32'(bus.ins_valid), 32'd1);
        check("stall.out", bus.ins_out, 32'h0000_0013);

        // Random phase against the address-level model.
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_line.delete();
        for (int n = 0; n < 60; n++) begin
            logic [31:0] pc;
            int lat;
            int clr;
            bit hit;
            pc  = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 7)) << 2);
            lat = int'($urandom_range(0, 4));
            clr = int'($urandom_range(0, 9));
            hit = model_line.exists(line_of(pc)) && (model_line[line_of(pc)] == pc);
            do_fetch($sformatf("rnd%0d", n), pc, mem_word(pc), lat, clr, 1'b1,
                     !hit, hit || (clr > lat), mem_word(pc));
            model_line[line_of(pc)] = pc;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
